data_mem_arbiter: RTL and testbench

Shares the single data memory port between the pipeline MEM stage and the debug unit's memory-dump engine. The pipeline has absolute priority and passes through combinationally with zero added latency. The debug side gets a sequencer that reads a block of consecutive words and streams them out over a valid/ready handshake, stealing only the cycles in which the pipeline issues no access. The block sits between the MEM stage and the data memory.

---
 rtl/mem_pkg.sv | 7 +
 rtl/data_mem_arbiter_if.sv | 36 +++
 rtl/data_mem_arbiter.sv | 65 ++++++
 tb/tb_data_mem_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: access-size codes shared with the data memory and the arbiter state enum
package mem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} arb_state_e;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: pipeline, debug-dump and memory-port signals; slave = arbiter, master = surroundings
interface data_mem_arbiter_if #(parameter int NBITS = 32, parameter int CNT_BITS = 10);
  logic                i_pl_en;
  logic                i_pl_write;
  logic [1:0]          i_pl_size;
  logic                i_pl_unsigned;
  logic [NBITS-1:0]    i_pl_addr;
  logic [NBITS-1:0]    i_pl_wdata;
  logic [NBITS-1:0]    o_pl_rdata;
  logic                i_dbg_start;
  logic [NBITS-1:0]    i_dbg_base;
  logic [CNT_BITS-1:0] i_dbg_count;
  logic [NBITS-1:0]    o_dbg_data;
  logic                o_dbg_valid;
  logic                i_dbg_ready;
  logic                o_dbg_busy;
  logic                o_dbg_done;
  logic                o_mem_write_en;
  logic [1:0]          o_mem_size;
  logic                o_mem_unsigned;
  logic [NBITS-1:0]    o_mem_addr;
  logic [NBITS-1:0]    o_mem_wdata;
  logic [NBITS-1:0]    i_mem_rdata;
  modport slave (
    input  i_pl_en, i_pl_write, i_pl_size, i_pl_unsigned, i_pl_addr, i_pl_wdata,
    input  i_dbg_start, i_dbg_base, i_dbg_count, i_dbg_ready, i_mem_rdata,
    output o_pl_rdata, o_dbg_data, o_dbg_valid, o_dbg_busy, o_dbg_done,
    output o_mem_write_en, o_mem_size, o_mem_unsigned, o_mem_addr, o_mem_wdata
  );
  modport master (
    output i_pl_en, i_pl_write, i_pl_size, i_pl_unsigned, i_pl_addr, i_pl_wdata,
    output i_dbg_start, i_dbg_base, i_dbg_count, i_dbg_ready, i_mem_rdata,
    input  o_pl_rdata, o_dbg_data, o_dbg_valid, o_dbg_busy, o_dbg_done,
    input  o_mem_write_en, o_mem_size, o_mem_unsigned, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: pipeline-priority memory mux plus a debug block-dump sequencer (ports: i_clk, i_rst, bus.slave)
module data_mem_arbiter
  import mem_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int CNT_BITS = 10
) (
  input logic                i_clk,
  input logic                i_rst,
  data_mem_arbiter_if.slave  bus
);
  arb_state_e          state_q, state_d;
  logic [NBITS-1:0]    addr_q, addr_d;
  logic [CNT_BITS-1:0] rem_q, rem_d;
  logic [NBITS-1:0]    data_q, data_d;
  logic                dbg_rd;
  // debug only reads in cycles the pipeline leaves the port free
  assign dbg_rd             = state_q == READ && !bus.i_pl_en;
  assign bus.o_mem_write_en = bus.i_pl_en & bus.i_pl_write;
  assign bus.o_mem_size     = bus.i_pl_en ? bus.i_pl_size : dbg_rd ? SIZE_WORD : 2'b00;
  assign bus.o_mem_unsigned = bus.i_pl_en & bus.i_pl_unsigned;
  assign bus.o_mem_addr     = bus.i_pl_en ? bus.i_pl_addr : dbg_rd ? addr_q : '0;
  assign bus.o_mem_wdata    = bus.i_pl_en ? bus.i_pl_wdata : '0;
  assign bus.o_pl_rdata     = bus.i_mem_rdata;
  assign bus.o_dbg_data     = data_q;
  assign bus.o_dbg_valid    = state_q == HOLD;
  assign bus.o_dbg_busy     = state_q != IDLE;
  assign bus.o_dbg_done     = state_q == DONE;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (bus.i_dbg_start) begin
        addr_d  = bus.i_dbg_base & ~NBITS'(3);
        rem_d   = bus.i_dbg_count;
        state_d = bus.i_dbg_count != '0 ? READ : DONE;
      end
      READ: if (!bus.i_pl_en) begin
        data_d  = bus.i_mem_rdata;
        state_d = HOLD;
      end
      HOLD: if (bus.i_dbg_ready) begin
        rem_d   = rem_q - 1'b1;
        state_d = rem_q == CNT_BITS'(1) ? DONE : READ;
        addr_d  = rem_q == CNT_BITS'(1) ? addr_q : addr_q + NBITS'(4);
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench for data_mem_arbiter with a small combinational memory model
module tb_data_mem_arbiter;
  import mem_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   acc_cnt = 0;
  logic [31:0] mem [64];
  logic [31:0] sb [$];
  data_mem_arbiter_if #(.NBITS(32), .CNT_BITS(10)) bus ();
  data_mem_arbiter #(.NBITS(32), .CNT_BITS(10)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.i_mem_rdata = mem[bus.o_mem_addr[7:2]];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 64; i++) mem[i] <= {8'hA5, 8'(i), 8'h3C, 8'(i * 7)};
    else if (bus.o_mem_write_en) mem[bus.o_mem_addr[7:2]] <= bus.o_mem_wdata;
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.o_dbg_valid && bus.i_dbg_ready) begin
      acc_cnt++;
      if (sb.size() == 0) chk("sb_unexpected_word", bus.o_dbg_data, 32'hx);
      else chk("dump_word", bus.o_dbg_data, sb.pop_front());
    end
  end
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic start_dump(logic [31:0] base, int count);
    logic [31:0] a;
    for (int k = 0; k < count; k++) begin
      a = (base & 32'hFFFF_FFFC) + 32'(4 * k);
      sb.push_back(mem[a[7:2]]);
    end
    bus.i_dbg_base  = base;
    bus.i_dbg_count = 10'(count);
    bus.i_dbg_start = 1;
    next();
    bus.i_dbg_start = 0;
  endtask
  task automatic wait_done(int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      if (bus.o_dbg_done) seen = 1;
      else next();
    end
    chk("done_seen", 32'(seen), 32'd1);
    next();
  endtask
  task automatic wait_valid(int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      if (bus.o_dbg_valid) seen = 1;
      else next();
    end
    chk("valid_seen", 32'(seen), 32'd1);
  endtask
  initial begin
    int a0;
    bus.i_pl_en = 0; bus.i_pl_write = 0; bus.i_pl_size = SIZE_WORD; bus.i_pl_unsigned = 0;
    bus.i_pl_addr = 0; bus.i_pl_wdata = 0; bus.i_dbg_ready = 1;
    bus.i_dbg_base = 32'h20; bus.i_dbg_count = 10'd3; bus.i_dbg_start = 1;
    next(); next();
    rst = 0;
    bus.i_dbg_start = 0;
    chk("rst_busy", 32'(bus.o_dbg_busy), 0);
    chk("rst_valid", 32'(bus.o_dbg_valid), 0);
    chk("rst_done", 32'(bus.o_dbg_done), 0);
    chk("rst_data", bus.o_dbg_data, 0);
    next();
    chk("start_in_rst_ignored", 32'(bus.o_dbg_busy), 0);
    // pipeline store then load
    bus.i_pl_en = 1; bus.i_pl_write = 1; bus.i_pl_size = SIZE_WORD; bus.i_pl_unsigned = 0;
    bus.i_pl_addr = 32'h10; bus.i_pl_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_we", 32'(bus.o_mem_write_en), 1);
    chk("st_addr", bus.o_mem_addr, 32'h10);
    chk("st_wdata", bus.o_mem_wdata, 32'hDEAD_BEEF);
    chk("st_size", 32'(bus.o_mem_size), 32'(SIZE_WORD));
    next();
    bus.i_pl_write = 0; bus.i_pl_size = SIZE_HALF; bus.i_pl_unsigned = 1; bus.i_pl_wdata = 32'h1234_5678;
    #1;
    chk("ld_rdata", bus.o_pl_rdata, 32'hDEAD_BEEF);
    chk("ld_we", 32'(bus.o_mem_write_en), 0);
    chk("ld_size", 32'(bus.o_mem_size), 32'(SIZE_HALF));
    chk("ld_unsigned", 32'(bus.o_mem_unsigned), 1);
    chk("ld_wdata", bus.o_mem_wdata, 32'h1234_5678);
    bus.i_pl_en = 0;
    #1;
    chk("idle_addr", bus.o_mem_addr, 0);
    chk("idle_we", 32'(bus.o_mem_write_en), 0);
    chk("idle_size", 32'(bus.o_mem_size), 0);
    chk("idle_unsigned", 32'(bus.o_mem_unsigned), 0);
    next();
    // basic dump with exact cycle timing
    start_dump(32'h20, 3);
    chk("read_addr", bus.o_mem_addr, 32'h20);
    chk("read_size", 32'(bus.o_mem_size), 32'(SIZE_WORD));
    for (int k = 1; k <= 6; k++) begin
      next();
      chk($sformatf("valid_c%0d", k), 32'(bus.o_dbg_valid), 32'(k % 2 == 1));
      chk($sformatf("done_c%0d", k), 32'(bus.o_dbg_done), 32'(k == 6));
    end
    next();
    chk("busy_after_done", 32'(bus.o_dbg_busy), 0);
    chk("sb_empty_basic", 32'(sb.size()), 0);
    // contention: pipeline owns the port for 5 cycles while in READ
    start_dump(32'h20, 3);
    bus.i_pl_en = 1; bus.i_pl_write = 0; bus.i_pl_size = SIZE_BYTE; bus.i_pl_addr = 32'h80;
    for (int k = 0; k < 5; k++) begin
      bus.i_pl_write = (k == 2);
      bus.i_pl_wdata = 32'h0BAD_F00D;
      #1;
      chk("cont_addr", bus.o_mem_addr, 32'h80);
      chk("cont_we", 32'(bus.o_mem_write_en), 32'(k == 2));
      chk("cont_size", 32'(bus.o_mem_size), 32'(SIZE_BYTE));
      next();
      chk("cont_no_valid", 32'(bus.o_dbg_valid), 0);
    end
    bus.i_pl_en = 0; bus.i_pl_write = 0;
    wait_done(20);
    chk("cont_store_landed", mem[32], 32'h0BAD_F00D);
    chk("sb_empty_cont", 32'(sb.size()), 0);
    // backpressure in HOLD
    bus.i_dbg_ready = 0;
    start_dump(32'h30, 2);
    wait_valid(10);
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", 32'(bus.o_dbg_valid), 1);
      chk("bp_data", bus.o_dbg_data, mem[12]);
      next();
    end
    bus.i_dbg_ready = 1;
    wait_done(20);
    chk("sb_empty_bp", 32'(sb.size()), 0);
    // zero count
    start_dump(32'h40, 0);
    chk("zero_done", 32'(bus.o_dbg_done), 1);
    chk("zero_valid", 32'(bus.o_dbg_valid), 0);
    chk("zero_busy", 32'(bus.o_dbg_busy), 1);
    next();
    chk("zero_done_once", 32'(bus.o_dbg_done), 0);
    chk("zero_idle", 32'(bus.o_dbg_busy), 0);
    // address wrap
    start_dump(32'hFFFF_FFFC, 2);
    chk("wrap_addr0", bus.o_mem_addr, 32'hFFFF_FFFC);
    next(); next();
    chk("wrap_addr1", bus.o_mem_addr, 32'h0);
    wait_done(20);
    chk("sb_empty_wrap", 32'(sb.size()), 0);
    // unaligned base
    start_dump(32'h13, 1);
    chk("align_addr", bus.o_mem_addr, 32'h10);
    wait_done(20);
    chk("sb_empty_align", 32'(sb.size()), 0);
    // reset mid-dump
    a0 = acc_cnt;
    start_dump(32'h40, 8);
    for (int i = 0; i < 40 && acc_cnt - a0 < 3; i++) next();
    chk("mid_accepts", 32'(acc_cnt - a0 >= 3), 1);
    rst = 1;
    next();
    rst = 0;
    sb.delete();
    chk("mid_rst_busy", 32'(bus.o_dbg_busy), 0);
    chk("mid_rst_valid", 32'(bus.o_dbg_valid), 0);
    chk("mid_rst_done", 32'(bus.o_dbg_done), 0);
    next();
    chk("post_rst_done", 32'(bus.o_dbg_done), 0);
    chk("post_rst_busy", 32'(bus.o_dbg_busy), 0);
    a0 = acc_cnt;
    start_dump(32'h40, 2);
    chk("fresh_addr", bus.o_mem_addr, 32'h40);
    wait_done(20);
    chk("fresh_words", 32'(acc_cnt - a0), 2);
    chk("sb_empty_end", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
